// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IREAD  = 2'd1,
        ST_DREAD  = 2'd2,
        ST_DWRITE = 2'd3
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] IO_SEL = 2'b11;

    // Size code 3 is illegal and is handled as a full word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Event counters for the memory arbiter: completed fetches, completed data
// transfers and cycles lost to a full IO transmit buffer.
module mem_arb_perf (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        if_done,
    input  logic        ls_done,
    input  logic        io_stall,
    output logic [31:0] perf_if_cnt,
    output logic [31:0] perf_ls_cnt,
    output logic [31:0] perf_stall_cnt
);

    // Each input is a single-cycle event already qualified by the global ready.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_if_cnt    <= '0;
            perf_ls_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (if_done)  perf_if_cnt    <= perf_if_cnt + 32'd1;
            if (ls_done)  perf_ls_cnt    <= perf_ls_cnt + 32'd1;
            if (io_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter between instruction fetch and load/store.
// Optional event counters are built when MEM_ARB_PERF_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer; arbitrate (data over fetch), mem_a/mem_wr = 0
// ST_IREAD  | fetching a word; present addr+idx, capture previous byte
// ST_DREAD  | loading 1/2/4 bytes; same sequencing as ST_IREAD
// ST_DWRITE | storing 1/2/4 bytes; one byte per cycle, never aborted
//
// In the read states idx is the offset currently on mem_a; the byte that
// arrives on mem_din belongs to lane idx-1. When idx reaches the byte count
// the final lane is merged and the done pulse is raised on the same edge.
module mem_arbiter #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_SEL     = mem_arb_pkg::IO_SEL
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  if_req_in,
    input  logic [31:0]           if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  ls_req_in,
    input  logic                  ls_wr_in,
    input  logic [1:0]            ls_size_in,
    input  logic [31:0]           ls_addr_in,
    input  logic [31:0]           ls_data_in,
    output logic                  ls_done_out,
    output logic [31:0]           ls_data_out
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_if_cnt_out,
    output logic [31:0]           perf_ls_cnt_out,
    output logic [31:0]           perf_stall_cnt_out
`endif
);

    import mem_arb_pkg::*;

    arb_state_t  state;
    logic [2:0]  idx;
    logic [2:0]  nbytes;
    logic [31:0] base;
    logic [31:0] wbuf;
    logic [31:0] rbuf;
    logic [31:0] rbuf_next;
    logic [31:0] next_addr;
    logic [1:0]  lane_rd;
    logic [1:0]  lane_wr;
    logic        mem_wr_q;
    logic        if_done_q;
    logic        ls_done_q;
    logic        is_io;

    // Stalled cycles must not write and must not show a done pulse; a pending
    // done simply reappears in the first ready cycle.
    assign mem_wr      = mem_wr_q & rdy_in;
    assign if_done_out = if_done_q & rdy_in;
    assign ls_done_out = ls_done_q & rdy_in;

    assign is_io = (ls_addr_in[17:16] == IO_SEL);

    // Address and lane arithmetic for the byte following the current one.
    always_comb begin
        next_addr = base + 32'(idx) + 32'd1;
        lane_rd   = 2'(idx - 3'd1);
        lane_wr   = 2'(idx + 3'd1);
    end

    // Read buffer with the byte arriving this cycle merged in; lanes beyond
    // the transfer size were cleared at acceptance, which zero-extends loads.
    always_comb begin
        rbuf_next = rbuf;
        if (idx != 3'd0) rbuf_next[{lane_rd, 3'b000} +: 8] = mem_din;
    end

    // Arbitration and byte sequencing; every register holds while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            idx         <= '0;
            nbytes      <= '0;
            base        <= '0;
            wbuf        <= '0;
            rbuf        <= '0;
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_data_out <= '0;
            ls_data_out <= '0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (ls_req_in) begin
                        // A stalled IO store blocks the fetch as well.
                        if (ls_wr_in) begin
                            if (!(is_io && io_buffer_full)) begin
                                state    <= ST_DWRITE;
                                base     <= ls_addr_in;
                                nbytes   <= size_to_bytes(ls_size_in);
                                wbuf     <= ls_data_in;
                                mem_a    <= ADDR_WIDTH'(ls_addr_in);
                                mem_dout <= ls_data_in[7:0];
                                mem_wr_q <= 1'b1;
                            end
                        end else if (!clear_in) begin
                            state  <= ST_DREAD;
                            base   <= ls_addr_in;
                            nbytes <= size_to_bytes(ls_size_in);
                            rbuf   <= '0;
                            mem_a  <= ADDR_WIDTH'(ls_addr_in);
                        end
                    end else if (if_req_in && !clear_in) begin
                        state  <= ST_IREAD;
                        base   <= if_addr_in;
                        nbytes <= 3'd4;
                        rbuf   <= '0;
                        mem_a  <= ADDR_WIDTH'(if_addr_in);
                    end
                end
                ST_IREAD, ST_DREAD: begin
                    if (clear_in) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        mem_a <= '0;
                    end else begin
                        rbuf <= rbuf_next;
                        if (idx == nbytes) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                            if (state == ST_IREAD) begin
                                if_done_q   <= 1'b1;
                                if_data_out <= rbuf_next;
                            end else begin
                                ls_done_q   <= 1'b1;
                                ls_data_out <= rbuf_next;
                            end
                        end else begin
                            idx   <= idx + 3'd1;
                            mem_a <= (idx == nbytes - 3'd1) ? '0 : ADDR_WIDTH'(next_addr);
                        end
                    end
                end
                ST_DWRITE: begin
                    if (idx == nbytes - 3'd1) begin
                        state     <= ST_IDLE;
                        idx       <= '0;
                        mem_a     <= '0;
                        mem_dout  <= '0;
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                    end else begin
                        idx      <= idx + 3'd1;
                        mem_a    <= ADDR_WIDTH'(next_addr);
                        mem_dout <= wbuf[{lane_wr, 3'b000} +: 8];
                        mem_wr_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic io_stall;

    assign io_stall = rdy_in && (state == ST_IDLE) && ls_req_in && ls_wr_in
                      && is_io && io_buffer_full;

    mem_arb_perf u_perf (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .if_done        (if_done_out),
        .ls_done        (ls_done_out),
        .io_stall       (io_stall),
        .perf_if_cnt    (perf_if_cnt_out),
        .perf_ls_cnt    (perf_ls_cnt_out),
        .perf_stall_cnt (perf_stall_cnt_out)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM environment, transaction-level reference
// model with a per-cycle compare, and directed scenarios with literal checks.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = '0;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        ls_req_in = 1'b0;
    logic        ls_wr_in = 1'b0;
    logic [1:0]  ls_size_in = '0;
    logic [31:0] ls_addr_in = '0;
    logic [31:0] ls_data_in = '0;
    logic        ls_done_out;
    logic [31:0] ls_data_out;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_cnt_out;
    logic [31:0] perf_ls_cnt_out;
    logic [31:0] perf_stall_cnt_out;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .if_req_in      (if_req_in),
        .if_addr_in     (if_addr_in),
        .if_done_out    (if_done_out),
        .if_data_out    (if_data_out),
        .ls_req_in      (ls_req_in),
        .ls_wr_in       (ls_wr_in),
        .ls_size_in     (ls_size_in),
        .ls_addr_in     (ls_addr_in),
        .ls_data_in     (ls_data_in),
        .ls_done_out    (ls_done_out),
        .ls_data_out    (ls_data_out)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_cnt_out    (perf_if_cnt_out),
        .perf_ls_cnt_out    (perf_ls_cnt_out),
        .perf_stall_cnt_out (perf_stall_cnt_out)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment RAM: one-cycle read latency, paused together with rdy_in.
    logic [7:0] ram  [0:65535];
    logic [7:0] mram [0:65535];

    always @(posedge clk_in) begin
        if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] <= mem_dout;
        if (rdy_in) mem_din <= ram[mem_a[15:0]];
    end

    // Reference model: one transaction at a time, m_k counts ready edges since
    // acceptance; reads present addr+k for k<N and finish at k=N+1, writes
    // drive byte k for k<N and finish at k=N.
    logic        m_busy;
    int          m_kind;
    logic [31:0] m_addr, m_wdata, m_if_data, m_ls_data;
    int          m_n, m_k;
    logic        m_if_pend, m_ls_pend;
    int          m_if_cnt, m_ls_cnt, m_stall_cnt;

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_busy = 0; m_kind = 0; m_addr = 0; m_wdata = 0;
            m_if_data = 0; m_ls_data = 0; m_n = 0; m_k = 0;
            m_if_pend = 0; m_ls_pend = 0;
            m_if_cnt = 0; m_ls_cnt = 0; m_stall_cnt = 0;
        end else if (rdy_in) begin
            if (m_if_pend) m_if_cnt++;
            if (m_ls_pend) m_ls_cnt++;
            m_if_pend = 0;
            m_ls_pend = 0;
            if (m_busy) begin
                if (m_kind != 2 && clear_in) begin
                    m_busy = 0;
                end else if (m_kind != 2 && m_k + 1 == m_n + 1) begin
                    logic [31:0] d;
                    d = 0;
                    for (int i = 0; i < m_n; i++) begin
                        logic [15:0] ai;
                        ai = m_addr[15:0] + 16'(i);
                        d[8*i +: 8] = mram[ai];
                    end
                    if (m_kind == 0) begin m_if_data = d; m_if_pend = 1; end
                    else begin m_ls_data = d; m_ls_pend = 1; end
                    m_busy = 0;
                end else if (m_kind == 2 && m_k + 1 == m_n) begin
                    m_ls_pend = 1;
                    m_busy = 0;
                end else begin
                    m_k++;
                end
            end else if (ls_req_in) begin
                if (ls_wr_in) begin
                    if (ls_addr_in[17:16] == 2'b11 && io_buffer_full) begin
                        m_stall_cnt++;
                    end else begin
                        m_busy = 1; m_kind = 2; m_k = 0;
                        m_addr = ls_addr_in; m_n = nb(ls_size_in); m_wdata = ls_data_in;
                        if (ls_addr_in[17:16] != 2'b11)
                            for (int i = 0; i < m_n; i++) begin
                                logic [15:0] ai;
                                ai = m_addr[15:0] + 16'(i);
                                mram[ai] = m_wdata[8*i +: 8];
                            end
                    end
                end else if (!clear_in) begin
                    m_busy = 1; m_kind = 1; m_k = 0;
                    m_addr = ls_addr_in; m_n = nb(ls_size_in);
                end
            end else if (if_req_in && !clear_in) begin
                m_busy = 1; m_kind = 0; m_k = 0; m_addr = if_addr_in; m_n = 4;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    logic exp_wr;
    always @(negedge clk_in) begin
        if (chk_en && !rst_in) begin
            check("if_done", if_done_out, m_if_pend && rdy_in);
            check("ls_done", ls_done_out, m_ls_pend && rdy_in);
            check("if_data", if_data_out, m_if_data);
            check("ls_data", ls_data_out, m_ls_data);
            exp_wr = rdy_in && m_busy && m_kind == 2 && m_k < m_n;
            check("mem_wr", mem_wr, exp_wr);
            if (exp_wr) check("mem_dout", mem_dout, m_wdata[8*m_k +: 8]);
            if (!m_busy) check("mem_a_idle", mem_a, 0);
            else if (m_k < m_n) check("mem_a", mem_a, m_addr + 32'(m_k));
`ifdef MEM_ARB_PERF_EN
            check("perf_if", perf_if_cnt_out, m_if_cnt);
            check("perf_ls", perf_ls_cnt_out, m_ls_cnt);
            check("perf_stall", perf_stall_cnt_out, m_stall_cnt);
`endif
        end
    end

    logic [31:0] wr_a [0:7];
    logic [7:0]  wr_d [0:7];
    int          wr_n;

    // Waits for a done pulse, counting edges after the accepting edge; an
    // optional rdy_in low window starts after lo_start edges for lo_len edges.
    task automatic wait_done(input bit use_ls, input int lo_start, input int lo_len, output int cyc);
        bit seen;
        cyc = 0; seen = 0; wr_n = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk_in); #1;
            if (mem_wr && wr_n < 8) begin
                wr_a[wr_n] = mem_a; wr_d[wr_n] = mem_dout; wr_n++;
            end
            if (use_ls ? ls_done_out : if_done_out) seen = 1;
            else begin
                cyc++;
                if (cyc == lo_start) rdy_in = 0;
                if (cyc == lo_start + lo_len) rdy_in = 1;
            end
        end
        rdy_in = 1;
        check("done_seen", 32'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    int c;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]  = 8'(i) ^ 8'h5A;
            mram[i] = 8'(i) ^ 8'h5A;
        end
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        ram[16'h0104] = 8'h93; ram[16'h0105] = 8'h00; ram[16'h0106] = 8'h10; ram[16'h0107] = 8'h00;
        ram[16'h1000] = 8'hFF; ram[16'h1001] = 8'h11; ram[16'h1002] = 8'h22; ram[16'h1003] = 8'h33;
        for (int i = 16'h0100; i < 16'h0108; i++) mram[i] = ram[i];
        for (int i = 16'h1000; i < 16'h1004; i++) mram[i] = ram[i];

        repeat (3) @(posedge clk_in);
        #1 rst_in = 0;
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_if_data", if_data_out, 0);
        check("rst_ls_data", ls_data_out, 0);
        check("rst_dones", {if_done_out, ls_done_out}, 0);
        chk_en = 1;

        // Word fetch.
        if_addr_in = 32'h100; if_req_in = 1;
        wait_done(0, 0, 0, c); if_req_in = 0;
        check("fetch_lat", c, 5);
        check("fetch_data", if_data_out, 32'h0000_0513);

        // Simultaneous load byte and fetch: load wins, fetch follows.
        ls_addr_in = 32'h1000; ls_size_in = 2'd0; ls_wr_in = 0; ls_req_in = 1;
        if_addr_in = 32'h104; if_req_in = 1;
        wait_done(1, 0, 0, c); ls_req_in = 0;
        check("prio_ls_lat", c, 2);
        check("prio_ls_data", ls_data_out, 32'h0000_00FF);
        check("prio_no_if_done", if_done_out, 0);
        wait_done(0, 0, 0, c); if_req_in = 0;
        check("prio_if_lat", c, 5);
        check("prio_if_data", if_data_out, 32'h0010_0093);

        // Store half.
        ls_addr_in = 32'h2002; ls_size_in = 2'd1; ls_wr_in = 1; ls_data_in = 32'h0000_BEEF; ls_req_in = 1;
        wait_done(1, 0, 0, c); ls_req_in = 0;
        check("sh_lat", c, 2);
        check("sh_nwr", wr_n, 2);
        check("sh_a0", wr_a[0], 32'h2002); check("sh_d0", wr_d[0], 8'hEF);
        check("sh_a1", wr_a[1], 32'h2003); check("sh_d1", wr_d[1], 8'hBE);

        // IO store blocked by a full transmit buffer for 3 cycles.
        ls_addr_in = 32'h30000; ls_size_in = 2'd0; ls_data_in = 32'h0000_00A5;
        io_buffer_full = 1; ls_req_in = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            check("io_stall_nowr", mem_wr, 0);
            check("io_stall_idle_a", mem_a, 0);
        end
        io_buffer_full = 0;
        wait_done(1, 0, 0, c); ls_req_in = 0;
        check("io_lat", c, 1);
        check("io_nwr", wr_n, 1);
        check("io_a", wr_a[0], 32'h30000);
        check("io_d", wr_d[0], 8'hA5);
`ifdef MEM_ARB_PERF_EN
        check("io_stall_cnt", perf_stall_cnt_out, 3);
`endif

        // Clear during the third cycle of a fetch, then a fresh fetch.
        if_addr_in = 32'h100; if_req_in = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            check("clr_no_done", if_done_out, 0);
        end
        clear_in = 1;
        @(posedge clk_in); #1;
        check("clr_no_done_abort", if_done_out, 0);
        check("clr_idle_a", mem_a, 0);
        clear_in = 0;
        wait_done(0, 0, 0, c); if_req_in = 0;
        check("clr_refetch_lat", c, 5);
        check("clr_refetch_data", if_data_out, 32'h0000_0513);

        // rdy_in low for 4 cycles in the middle of a word load.
        ls_addr_in = 32'h1000; ls_size_in = 2'd2; ls_wr_in = 0; ls_req_in = 1;
        wait_done(1, 2, 4, c); ls_req_in = 0;
        check("rdy_lat", c, 9);
        check("rdy_data", ls_data_out, 32'h3322_11FF);
        check("rdy_nwr", wr_n, 0);

        // Store word, then read back as half (zero-extended) and as size 3.
        ls_addr_in = 32'h2100; ls_size_in = 2'd2; ls_wr_in = 1; ls_data_in = 32'hDEAD_BEEF; ls_req_in = 1;
        wait_done(1, 0, 0, c); ls_req_in = 0;
        check("sw_lat", c, 4);
        check("sw_nwr", wr_n, 4);
        ls_addr_in = 32'h2102; ls_size_in = 2'd1; ls_wr_in = 0; ls_req_in = 1;
        wait_done(1, 0, 0, c); ls_req_in = 0;
        check("lh_lat", c, 3);
        check("lh_data", ls_data_out, 32'h0000_DEAD);
        ls_addr_in = 32'h2100; ls_size_in = 2'd3; ls_req_in = 1;
        wait_done(1, 0, 0, c); ls_req_in = 0;
        check("lsz3_lat", c, 5);
        check("lsz3_data", ls_data_out, 32'hDEAD_BEEF);

        // Clear in IDLE suppresses a load request.
        clear_in = 1;
        ls_addr_in = 32'h1000; ls_size_in = 2'd0; ls_req_in = 1;
        repeat (2) begin
            @(posedge clk_in); #1;
            check("clr_idle_noacc", mem_a, 0);
        end
        clear_in = 0;
        wait_done(1, 0, 0, c); ls_req_in = 0;
        check("clr_idle_lat", c, 2);
        check("clr_idle_data", ls_data_out, 32'h0000_00FF);

`ifdef MEM_ARB_PERF_EN
        check("perf_if_total", perf_if_cnt_out, 3);
        check("perf_ls_total", perf_ls_cnt_out, 8);
`endif

        // Asynchronous reset in the middle of a fetch.
        if_addr_in = 32'h100; if_req_in = 1;
        repeat (2) @(posedge clk_in);
        #1;
        check("rstmid_a_before", mem_a, 32'h101);
        rst_in = 1;
        #1;
        check("rstmid_a", mem_a, 0);
        check("rstmid_wr", mem_wr, 0);
        check("rstmid_if_data", if_data_out, 0);
        if_req_in = 0;
        @(posedge clk_in); #1;
        rst_in = 0;
        repeat (3) @(posedge clk_in);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
